// File: rtl/fetch_exec_prims.sv
// Datapath primitives for the RV32I fetch/execute stages: instruction memory,
// PC+4 incrementer and a 32-bit ALU. Reads and compute are combinational.
module fetch_exec_prims #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  input  logic [31:0] alu_in1,
  input  logic [31:0] alu_in2,
  input  logic [3:0]  alu_sel,
  output logic [31:0] alu_out,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata
);

  localparam int unsigned AW  = $clog2(IMEM_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // Unloaded words read as NOP so a partially loaded program runs safely.
  logic [31:0] mem [IMEM_DEPTH] = '{default: NOP};

  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;

  assign raddr = pc[AW+1:2];
  assign waddr = imem_waddr[AW+1:2];

  // Reset only suppresses the load port; program contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && imem_we) begin
      mem[waddr] <= imem_wdata;
    end
  end

  assign inst     = mem[raddr];
  assign pc_plus4 = pc + 32'd4;

  logic [4:0] shamt;
  assign shamt = alu_in2[4:0];

  always_comb begin
    alu_out = '0;
    case (alu_op_e'(alu_sel))
      ALU_ADD:   alu_out = alu_in1 + alu_in2;
      ALU_SUB:   alu_out = alu_in1 - alu_in2;
      ALU_SLL:   alu_out = alu_in1 << shamt;
      ALU_SLT:   alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
      ALU_SLTU:  alu_out = {31'd0, alu_in1 < alu_in2};
      ALU_XOR:   alu_out = alu_in1 ^ alu_in2;
      ALU_SRL:   alu_out = alu_in1 >> shamt;
      ALU_SRA:   alu_out = $unsigned($signed(alu_in1) >>> shamt);
      ALU_OR:    alu_out = alu_in1 | alu_in2;
      ALU_AND:   alu_out = alu_in1 & alu_in2;
      ALU_PASSB: alu_out = alu_in2;
      default:   alu_out = '0;
    endcase
  end

endmodule

// File: tb/tb_fetch_exec_prims.sv
// Directed self-checking bench for fetch_exec_prims: IMEM read/write/wrap,
// reset blocking of the load port, PC+4 wrap and every ALU operation.
module tb_fetch_exec_prims;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] inst;
   logic [31:0] pc_plus4;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [3:0]  alu_sel;
   logic [31:0] alu_out;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   fetch_exec_prims #(
      .IMEM_DEPTH(256),
      .INIT_FILE ("")
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .inst      (inst),
      .pc_plus4  (pc_plus4),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .imem_we   (imem_we),
      .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      imem_we    = 1'b1;
      imem_waddr = addr;
      imem_wdata = data;
      @(posedge clk);
      #1 imem_we = 1'b0;
   endtask

   task automatic read_at(input logic [31:0] addr, input string tag, input logic [31:0] exp);
      pc = addr;
      #1 check(tag, inst, exp);
   endtask

   task automatic alu_vec(input string tag, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      alu_sel = sel;
      alu_in1 = a;
      alu_in2 = b;
      #1 check(tag, alu_out, exp);
   endtask

   initial begin
      rst        = 1'b1;
      pc         = '0;
      alu_in1    = '0;
      alu_in2    = '0;
      alu_sel    = '0;
      imem_we    = 1'b0;
      imem_waddr = '0;
      imem_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Power-up contents and PC increment
      read_at(32'h0, "inst_pc0_nop", 32'h0000_0013);
      check("pc_plus4_0", pc_plus4, 32'd4);
      pc = 32'hFFFF_FFFC;
      #1 check("pc_plus4_wrap", pc_plus4, 32'h0);
      read_at(32'd40, "inst_pc40_nop", 32'h0000_0013);

      // Write with same-cycle read of the target address
      @(negedge clk);
      imem_we    = 1'b1;
      imem_waddr = 32'd8;
      imem_wdata = 32'h00A0_0093;
      pc         = 32'd8;
      #1 check("inst_write_cycle_old", inst, 32'h0000_0013);
      @(posedge clk);
      #1 imem_we = 1'b0;
      read_at(32'd8,    "inst_pc8_new",   32'h00A0_0093);
      read_at(32'd9,    "inst_pc9_low",   32'h00A0_0093);
      read_at(32'd1032, "inst_pc1032_wrap", 32'h00A0_0093);
      read_at(32'd4,    "inst_pc4_untouched", 32'h0000_0013);

      // Reset blocks the load port and preserves existing words
      load_word(32'd12, 32'h1234_5678);
      read_at(32'd12, "inst_pc12_loaded", 32'h1234_5678);
      @(negedge clk);
      rst        = 1'b1;
      imem_we    = 1'b1;
      imem_waddr = 32'd12;
      imem_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 begin
         rst     = 1'b0;
         imem_we = 1'b0;
      end
      read_at(32'd12, "inst_pc12_rst_blocked", 32'h1234_5678);
      read_at(32'd8,  "inst_pc8_after_rst",    32'h00A0_0093);
      load_word(32'd13, 32'hCAFE_F00D);
      read_at(32'd12, "inst_pc12_post_rst_write", 32'hCAFE_F00D);

      // ALU: sign boundary operands
      alu_vec("alu_add_min",  4'd0, 32'h8000_0000, 32'd1, 32'h8000_0001);
      alu_vec("alu_sub_min",  4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
      alu_vec("alu_slt_min",  4'd3, 32'h8000_0000, 32'd1, 32'd1);
      alu_vec("alu_sltu_min", 4'd4, 32'h8000_0000, 32'd1, 32'd0);
      alu_vec("alu_sra_min",  4'd7, 32'h8000_0000, 32'd1, 32'hC000_0000);
      alu_vec("alu_srl_min",  4'd6, 32'h8000_0000, 32'd1, 32'h4000_0000);

      // ALU: logic ops and shift amount masking
      alu_vec("alu_sll_mask", 4'd2,  32'hF0F0_F0F0, 32'h24, 32'h0F0F_0F00);
      alu_vec("alu_xor",      4'd5,  32'hF0F0_F0F0, 32'h24, 32'hF0F0_F0D4);
      alu_vec("alu_or",       4'd8,  32'hF0F0_F0F0, 32'h24, 32'hF0F0_F0F4);
      alu_vec("alu_and",      4'd9,  32'hF0F0_F0F0, 32'h24, 32'h0000_0020);
      alu_vec("alu_passb",    4'd10, 32'hF0F0_F0F0, 32'h24, 32'h0000_0024);
      alu_vec("alu_sel15",    4'd15, 32'hF0F0_F0F0, 32'h24, 32'h0);
      alu_vec("alu_sel11",    4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
      alu_vec("alu_srl_mask", 4'd6,  32'hF0F0_F0F0, 32'h24, 32'h0F0F_0F0F);
      alu_vec("alu_sra_mask", 4'd7,  32'hF0F0_F0F0, 32'h24, 32'hFF0F_0F0F);

      // ALU: further signed/unsigned compare cases
      alu_vec("alu_slt_pos",  4'd3, 32'd1, 32'hFFFF_FFFF, 32'd0);
      alu_vec("alu_sltu_big", 4'd4, 32'd1, 32'hFFFF_FFFF, 32'd1);
      alu_vec("alu_slt_eq",   4'd3, 32'd7, 32'd7, 32'd0);

      // F-stage branch target and add wrap
      alu_vec("alu_target",   4'd0, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0000_00F0);
      alu_vec("alu_add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1);
      alu_vec("alu_sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
